// File: rtl/csa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// csa_stream_accumulator
//
// Purpose
//   Sums a variable-length stream of unsigned WIDTH-bit operands (1..MAX_OPS
//   per transaction). Each accepted operand is folded into a redundant
//   sum/carry pair with one 3:2 compression, so the per-beat critical path is a
//   single full-adder level regardless of ACC_W. One carry-propagate add
//   resolves the pair once the transaction's last operand has arrived.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      operand beat valid
//   in_ready      out  1      block can accept an operand (state decode only)
//   in_data       in   WIDTH  operand, unsigned, zero-extended to ACC_W
//   in_last       in   1      final operand of the transaction
//   out_valid     out  1      result valid
//   out_ready     in   1      consumer accepts result
//   out_sum       out  ACC_W  sum of the transaction operands, mod 2^ACC_W
//   out_count     out  CNT_W  operands accepted, saturating at MAX_OPS
//   out_overflow  out  1      more than MAX_OPS operands were accepted
//
// Flow: ACCUM (take beats) -> RESOLVE (one cycle, final add) -> OUTPUT (hold
// result until out_ready) -> ACCUM.
// -----------------------------------------------------------------------------
module csa_stream_accumulator #(
    parameter  int WIDTH   = 4,
    parameter  int MAX_OPS = 16,
    localparam int ACC_W   = WIDTH + $clog2(MAX_OPS),
    localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OPS);

    // 3:2 compressor, sum half.
    function automatic logic [ACC_W-1:0] csa_sum(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        return a ^ b ^ c;
    endfunction

    // 3:2 compressor, carry half. The carry out of the top bit is dropped,
    // which is exactly the mod 2^ACC_W wrap the result is defined with.
    function automatic logic [ACC_W-1:0] csa_carry(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    // Operand counter increment, saturating at MAX_OPS.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    state_t           state_q,     state_d;
    logic [ACC_W-1:0] s_reg_q,     s_reg_d;
    logic [ACC_W-1:0] c_reg_q,     c_reg_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    logic             beat;
    logic [ACC_W-1:0] operand;

    assign beat    = in_valid & in_ready_q;
    assign operand = ACC_W'(in_data);

    always_comb begin
        state_d     = state_q;
        s_reg_d     = s_reg_q;
        c_reg_d     = c_reg_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ST_ACCUM: begin
                if (beat) begin
                    s_reg_d = csa_sum(s_reg_q, c_reg_q, operand);
                    c_reg_d = csa_carry(s_reg_q, c_reg_q, operand);
                    count_d = sat_inc(count_q);
                    // Overflow is flagged by the first beat that arrives
                    // with the counter already full.
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end

            ST_RESOLVE: begin
                out_sum_d   = s_reg_q + c_reg_q;
                out_count_d = count_q;
                out_ovf_d   = ovf_q;
                state_d     = ST_OUTPUT;
            end

            ST_OUTPUT: begin
                if (out_ready) begin
                    s_reg_d = '0;
                    c_reg_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        // Handshake flags are decoded from the next state and registered, so
        // neither depends combinationally on in_valid or out_ready.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            s_reg_q     <= '0;
            c_reg_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_reg_q     <= s_reg_d;
            c_reg_q     <= c_reg_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// tb_csa_stream_accumulator
//
// Bench for csa_stream_accumulator with WIDTH=4, MAX_OPS=16 (ACC_W=8,
// CNT_W=5). Directed vectors come from a table of {operand count, operand
// value, expected sum/count/overflow}; multi-cycle corner cases are written out
// by hand; random transactions are checked against a plain integer sum model.
// All driving and sampling happens 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_csa_stream_accumulator;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 16;
    localparam int ACC_W   = 8;
    localparam int CNT_W   = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int errors = 0;
    int checks = 0;

    csa_stream_accumulator #(
        .WIDTH   (WIDTH),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             n;
        logic [WIDTH-1:0] val;
        logic [ACC_W-1:0] es;
        logic [CNT_W-1:0] ec;
        logic           eo;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, optionally preceded by idle cycles carrying junk
    // data that must be ignored. Returns after the accepting edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
            in_last  = 1'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, hold off for 'hold' cycles checking it stays put, then
    // accept it and check out_valid drops.
    task automatic recv(input logic [ACC_W-1:0] es, input logic [CNT_W-1:0] ec,
                        input logic eo, input int hold, input bit early, input string nm);
        int waited;
        out_ready = early;
        waited    = 0;
        while (!out_valid && waited < 200) begin
            step();
            waited++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1", nm);
            out_ready = 1'b0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            check({nm, "_hold_sum"}, out_sum, es);
            check({nm, "_hold_inrdy"}, in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        check({nm, "_vld"}, out_valid, 1);
        check({nm, "_sum"}, out_sum, es);
        check({nm, "_cnt"}, out_count, ec);
        check({nm, "_ovf"}, out_overflow, eo);
        step();
        out_ready = 1'b0;
        check({nm, "_vld_fall"}, out_valid, 0);
    endtask

    initial begin
        tbl[0] = '{3,  4'd1,  8'd3,   5'd3,  1'b0};
        tbl[1] = '{3,  4'd8,  8'd24,  5'd3,  1'b0};
        tbl[2] = '{3,  4'd0,  8'd0,   5'd3,  1'b0};
        tbl[3] = '{1,  4'd15, 8'd15,  5'd1,  1'b0};
        tbl[4] = '{1,  4'd7,  8'd7,   5'd1,  1'b0};
        tbl[5] = '{16, 4'd15, 8'd240, 5'd16, 1'b0};
        tbl[6] = '{17, 4'd15, 8'd255, 5'd16, 1'b1};
        tbl[7] = '{18, 4'd15, 8'd14,  5'd16, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_overflow, 0);
        rst_n = 1'b1;

        // Latency: 1,1,1 -> RESOLVE after last edge, OUTPUT one edge later
        send_beat(4'd1, 1'b0, 0);
        send_beat(4'd1, 1'b0, 0);
        send_beat(4'd1, 1'b1, 0);
        check("lat_resolve_vld", out_valid, 0);
        check("lat_resolve_inrdy", in_ready, 0);
        step();
        check("lat_output_vld", out_valid, 1);
        recv(8'd3, 5'd3, 1'b0, 0, 1'b0, "lat");

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < tbl[v].n; i++) begin
                send_beat(tbl[v].val, (i == tbl[v].n - 1), 0);
            end
            recv(tbl[v].es, tbl[v].ec, tbl[v].eo, 0, 1'b0, $sformatf("tbl%0d", v));
        end

        // Backpressure: result held 5 cycles while junk beats are offered
        send_beat(4'd9, 1'b1, 0);
        begin
            int waited;
            waited = 0;
            while (!out_valid && waited < 20) begin
                step();
                waited++;
            end
        end
        for (int h = 0; h < 5; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 4'd6;
            in_last   = 1'b1;
            check("bp_vld", out_valid, 1);
            check("bp_inrdy", in_ready, 0);
            check("bp_sum", out_sum, 9);
            check("bp_cnt", out_count, 1);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_inrdy", in_ready, 1);
        check("bp_release_vld", out_valid, 0);
        send_beat(4'd4, 1'b1, 0);
        recv(8'd4, 5'd1, 1'b0, 0, 1'b0, "bp_next");

        // Reset mid-transaction discards partial sum
        send_beat(4'd5, 1'b0, 0);
        send_beat(4'd6, 1'b0, 0);
        rst_n = 1'b0;
        #2;
        check("midrst_inrdy", in_ready, 0);
        check("midrst_vld", out_valid, 0);
        step();
        rst_n = 1'b1;
        send_beat(4'd2, 1'b0, 0);
        send_beat(4'd3, 1'b1, 0);
        recv(8'd5, 5'd2, 1'b0, 0, 1'b0, "midrst");

        // Random transactions vs integer sum model
        for (int t = 0; t < 1000; t++) begin
            int n;
            int sum;
            logic [WIDTH-1:0] d;
            n   = $urandom_range(1, 20);
            sum = 0;
            for (int i = 0; i < n; i++) begin
                d   = WIDTH'($urandom);
                sum = sum + int'(d);
                send_beat(d, (i == n - 1), $urandom_range(0, 2));
            end
            recv(ACC_W'(sum % 256), CNT_W'((n > MAX_OPS) ? MAX_OPS : n),
                 (n > MAX_OPS), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
